// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection controller for a gene-network cell array: finds attractor period, transient and an attractor state.
// `define GNR_TRANSIENT_EN adds the reload/advance/meet phases for exact transient; otherwise transient reports 0.
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               nodes_reset,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               found,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   transient,
    output logic [N_NODES-1:0] attractor
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_F_STEP,
        S_F_CHK,
        S_L_STEP,
        S_L_CHK,
`ifdef GNR_TRANSIENT_EN
        S_RELOAD,
        S_A_STEP,
        S_A_CHK,
        S_M_CHK,
        S_M_STEP,
        S_M_PAD,
`endif
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   r_l;
`ifdef GNR_TRANSIENT_EN
    logic [CNT_W-1:0]   r_a;
    logic [CNT_W-1:0]   r_m;
`endif
    logic               r_busy;
    logic               r_nodes_reset;
    logic               r_start_s0;
    logic               r_start_s1;
    logic               r_res_valid;
    logic               r_found;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_transient;
    logic [N_NODES-1:0] r_attractor;

    logic w_eq;
    logic w_busy_nxt;
    logic w_nodes_reset_nxt;
    logic w_start_s0_nxt;
    logic w_start_s1_nxt;
    logic w_res_valid_nxt;

    assign w_eq = (s0_vec == s1_vec);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State register plus counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_l           <= '0;
`ifdef GNR_TRANSIENT_EN
            r_a           <= '0;
            r_m           <= '0;
`endif
            r_busy        <= 1'b0;
            r_nodes_reset <= 1'b0;
            r_start_s0    <= 1'b0;
            r_start_s1    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_found       <= 1'b0;
            r_period      <= '0;
            r_transient   <= '0;
            r_attractor   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= w_busy_nxt;
            r_nodes_reset <= w_nodes_reset_nxt;
            r_start_s0    <= w_start_s0_nxt;
            r_start_s1    <= w_start_s1_nxt;
            r_res_valid   <= w_res_valid_nxt;
            case (r_state)
                S_LOAD: begin
                    r_n         <= '0;
                    r_found     <= 1'b0;
                    r_period    <= '0;
                    r_transient <= '0;
                    r_attractor <= '0;
                end
                S_F_STEP: r_n <= sat_inc(r_n);
                S_F_CHK:  r_l <= '0;
                S_L_STEP: r_l <= sat_inc(r_l);
                S_L_CHK: begin
                    if (w_eq) begin
                        r_period <= r_l;
`ifndef GNR_TRANSIENT_EN
                        // Meeting point is on the cycle but not necessarily its entry
                        r_found     <= 1'b1;
                        r_transient <= '0;
                        r_attractor <= s0_vec;
`endif
                    end
                end
`ifdef GNR_TRANSIENT_EN
                S_RELOAD: begin
                    r_a <= '0;
                    r_m <= '0;
                end
                S_A_STEP: r_a <= sat_inc(r_a);
                S_M_CHK: begin
                    if (w_eq) begin
                        r_found     <= 1'b1;
                        r_transient <= r_m;
                        r_attractor <= s0_vec;
                    end
                end
                S_M_STEP: r_m <= sat_inc(r_m);
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_F_STEP;
            S_F_STEP: w_state_nxt = S_F_CHK;
            S_F_CHK: begin
                if (r_n >= CNT_W'(2) && w_eq)
                    w_state_nxt = S_L_STEP;
                else if (r_n == MAX_C)
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_F_STEP;
            end
            S_L_STEP: w_state_nxt = S_L_CHK;
            S_L_CHK: begin
`ifdef GNR_TRANSIENT_EN
                w_state_nxt = w_eq ? S_RELOAD : S_L_STEP;
`else
                w_state_nxt = w_eq ? S_DONE : S_L_STEP;
`endif
            end
`ifdef GNR_TRANSIENT_EN
            S_RELOAD: w_state_nxt = (r_period == '0) ? S_M_CHK : S_A_STEP;
            S_A_STEP: w_state_nxt = S_A_CHK;
            // Hare leads the tortoise by exactly lambda before the meet phase
            S_A_CHK:  w_state_nxt = (r_a >= r_period) ? S_M_CHK : S_A_STEP;
            S_M_CHK:  w_state_nxt = w_eq ? S_DONE : S_M_STEP;
            S_M_STEP: w_state_nxt = S_M_PAD;
            S_M_PAD:  w_state_nxt = S_M_CHK;
`endif
            S_DONE:   if (res_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the flops line up with the state they belong to
    always_comb begin
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_res_valid_nxt   = (w_state_nxt == S_DONE);
        w_nodes_reset_nxt = (w_state_nxt == S_LOAD);
        w_start_s0_nxt    = (w_state_nxt == S_F_STEP);
        w_start_s1_nxt    = (w_state_nxt == S_F_STEP) || (w_state_nxt == S_L_STEP);
`ifdef GNR_TRANSIENT_EN
        w_nodes_reset_nxt = w_nodes_reset_nxt || (w_state_nxt == S_RELOAD);
        // M_PAD pulses s0 alone so the tortoise pass bit is re-armed
        w_start_s0_nxt    = w_start_s0_nxt || (w_state_nxt == S_M_STEP) || (w_state_nxt == S_M_PAD);
        w_start_s1_nxt    = w_start_s1_nxt || (w_state_nxt == S_A_STEP) || (w_state_nxt == S_M_STEP);
`endif
    end

    assign busy        = r_busy;
    assign nodes_reset = r_nodes_reset;
    assign start_s0    = r_start_s0;
    assign start_s1    = r_start_s1;
    assign res_valid   = r_res_valid;
    assign found       = r_found;
    assign period      = r_period;
    assign transient   = r_transient;
    assign attractor   = r_attractor;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a behavioural cell-array model; honours `GNR_TRANSIENT_EN.
module tb_gnr_attractor_ctrl;

    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         res_ready = 1'b0;
    logic         busy, nodes_reset, start_s0, start_s1, res_valid, found;
    logic [W-1:0] period, transient;
    logic [N-1:0] attractor;
    logic [N-1:0] s0 = '0;
    logic [N-1:0] s1 = '0;
    logic         pass = 1'b1;

    int           mode = 0;
    logic [N-1:0] init_st = '0;
    logic         clr = 1'b0;
    int           cnt_s0 = 0, cnt_s1 = 0, cnt_s0only = 0;
    int           cnt_idle_pulse = 0, cnt_viol = 0;
    logic         p1 = 1'b0, p2 = 1'b0, ps1 = 1'b0;
    int           n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .nodes_reset(nodes_reset), .start_s0(start_s0), .start_s1(start_s1),
        .s0_vec(s0), .s1_vec(s1), .res_valid(res_valid), .res_ready(res_ready),
        .found(found), .period(period), .transient(transient), .attractor(attractor)
    );

    // mode 0: fixed point; mode 1: mu=3 lambda=4 chain from 8'h10; mode 2: 64-cycle counter
    function automatic logic [N-1:0] f(input logic [N-1:0] x, input int md);
        if (md == 0) return x;
        if (md == 2) return (x + 8'd1) & 8'h3F;
        case (x)
            8'h10:   return 8'h21;
            8'h21:   return 8'h32;
            8'h32:   return 8'h43;
            8'h43:   return 8'h54;
            8'h54:   return 8'h65;
            8'h65:   return 8'h76;
            8'h76:   return 8'h43;
            default: return x;
        endcase
    endfunction

    always @(posedge clk) begin
        if (nodes_reset) begin
            s0   <= init_st;
            s1   <= init_st;
            pass <= 1'b1;
        end else begin
            if (start_s0) begin
                if (pass) s0 <= f(s0, mode);
                pass <= ~pass;
            end
            if (start_s1) s1 <= f(s1, mode);
        end
    end

    // Pulse monitor: per-run counts plus protocol violations (no pulse in a check cycle)
    always @(posedge clk) begin
        if (clr) begin
            cnt_s0 <= 0; cnt_s1 <= 0; cnt_s0only <= 0;
        end else begin
            if (start_s0) cnt_s0 <= cnt_s0 + 1;
            if (start_s1) cnt_s1 <= cnt_s1 + 1;
            if (start_s0 && !start_s1) cnt_s0only <= cnt_s0only + 1;
        end
        if ((start_s0 || start_s1 || nodes_reset) && !busy) cnt_idle_pulse <= cnt_idle_pulse + 1;
        if ((start_s0 || start_s1) && p1 && p2) cnt_viol <= cnt_viol + 1;
        if (start_s1 && ps1) cnt_viol <= cnt_viol + 1;
        p2  <= p1;
        p1  <= start_s0 || start_s1;
        ps1 <= start_s1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int md, input logic [N-1:0] ini);
        mode    = md;
        init_st = ini;
        clr     = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!res_valid && k < 2000) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic f_exp, input int p_exp,
                                input int t_exp, input logic [N-1:0] a_exp);
        chk({tag, "_found"}, {31'd0, found}, {31'd0, f_exp});
        chk({tag, "_period"}, {16'd0, period}, p_exp);
        chk({tag, "_transient"}, {16'd0, transient}, t_exp);
        chk({tag, "_attractor"}, {24'd0, attractor}, {24'd0, a_exp});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_mu3(input string tag);
`ifdef GNR_TRANSIENT_EN
        check_result(tag, 1'b1, 4, 3, 8'h43);
`else
        check_result(tag, 1'b1, 4, 0, 8'h54);
`endif
    endtask

    initial begin
        int k;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_pulses", {29'd0, nodes_reset, start_s0, start_s1}, 32'd0);
        chk("rst_results", {found, 7'd0, attractor, period}, 32'd0);
        rst = 1'b0;
        tick();

        // Fixed point at init
        launch(0, 8'h5A);
        wait_valid("fix_wait");
        check_result("fix", 1'b1, 1, 0, 8'h5A);
        chk("fix_s0_pulses", cnt_s0, 2);
`ifdef GNR_TRANSIENT_EN
        chk("fix_s1_pulses", cnt_s1, 4);
`else
        chk("fix_s1_pulses", cnt_s1, 3);
`endif
        accept("fix");

        // Timeout on a 64-cycle with MAX_STEPS=16
        launch(2, 8'h00);
        wait_valid("to_wait");
        check_result("to", 1'b0, 0, 0, 8'h00);
        chk("to_s0_pulses", cnt_s0, 16);
        chk("to_s1_pulses", cnt_s1, 16);
        accept("to");

        // mu=3 lambda=4, result held 20 cycles with a stray start
        launch(1, 8'h10);
        wait_valid("mu3_wait");
        run_mu3("mu3");
`ifdef GNR_TRANSIENT_EN
        chk("mu3_s0_pulses", cnt_s0, 14);
        chk("mu3_s1_pulses", cnt_s1, 19);
        chk("mu3_mpad_pulses", cnt_s0only, 3);
`else
        chk("mu3_s0_pulses", cnt_s0, 8);
        chk("mu3_s1_pulses", cnt_s1, 12);
        chk("mu3_mpad_pulses", cnt_s0only, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            chk("hold_period", {16'd0, period}, 32'd4);
        end
        start = 1'b0;
        run_mu3("hold_end");
        accept("mu3");
        tick();
        chk("idle_after_accept", {31'd0, busy}, 32'd0);

        // Reset during L_STEP aborts the run
        launch(1, 8'h10);
        k = 0;
        while (!(start_s1 && !start_s0 && busy) && k < 500) begin
            tick();
            k++;
        end
        chk("abort_reach_lstep", {31'd0, start_s1 & ~start_s0}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_pulses", {29'd0, nodes_reset, start_s0, start_s1}, 32'd0);
        chk("abort_results", {found, 7'd0, attractor, period}, 32'd0);
        chk("abort_transient", {16'd0, transient}, 32'd0);
        tick();
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        launch(1, 8'h10);
        wait_valid("rerun_wait");
        run_mu3("rerun");
        accept("rerun");

        chk("no_pulse_when_idle", cnt_idle_pulse, 0);
        chk("no_pulse_in_check", cnt_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Downstream controller for an array of gene-network node cells. Each cell holds two state copies: s0 is the tortoise and advances on every second start_s0 pulse; s1 is the hare and advances on every start_s1 pulse.
- Consumes the concatenated s0/s1 state vectors and drives the cells' reset_nos/start_s0/start_s1.
- Runs Floyd cycle detection to report attractor period (lambda), transient length (mu) and one attractor state.

Parameters:
N_NODES, 8, width of state vectors (one bit per node)
CNT_W, 16, width of step counters and results
MAX_STEPS, 1000, hare-step limit in FIND before timeout

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  begin run; accepted only in IDLE
busy  out  1  high from accepted start until result accepted
nodes_reset  out  1  to all cells' reset_nos (loads init_state, pass=1)
start_s0  out  1  to all cells' start_s0
start_s1  out  1  to all cells' start_s1
s0_vec  in  N_NODES  concatenated cell s0 outputs
s1_vec  in  N_NODES  concatenated cell s1 outputs
res_valid  out  1  result valid
res_ready  in  1  result accepted when res_valid&res_ready
found  out  1  1 = attractor found, 0 = timeout
period  out  CNT_W  lambda
transient  out  CNT_W  mu
attractor  out  N_NODES  state on the attractor

Behaviour:
- Reset: state IDLE. All outputs are 0, all counters are 0. Reset mid-run aborts immediately, with no result.
- Step rule: every "step" is a pulse cycle followed by a check cycle with no pulses. Compares use s0_vec==s1_vec in the check cycle, because cell outputs are registered.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: nodes_reset=1 for one cycle; clear n -> F_STEP.
  - F_STEP: start_s0=start_s1=1; n++ -> F_CHK.
  - F_CHK: after n steps the hare is at step n and the tortoise at ceil(n/2).
    - If n>=2 and vectors are equal -> L_STEP with l=0.
    - Else if n==MAX_STEPS -> DONE with found=0, period=transient=0, attractor=0.
    - Else -> F_STEP.
  - L_STEP: start_s1=1 only; l++ -> L_CHK.
  - L_CHK: equal -> period=l, then RELOAD (or DONE without the feature); else -> L_STEP.
  - RELOAD: nodes_reset=1; a=0 -> A_STEP, or M_CHK directly if period==0 (not reachable).
  - A_STEP/A_CHK: start_s1 only, period times (hare lead = lambda). Then M_CHK with m=0.
  - M_CHK: equal -> transient=m, attractor=s0_vec, found=1 -> DONE. Else -> M_STEP.
  - M_STEP: start_s0=start_s1=1; m++ -> M_PAD.
  - M_PAD: start_s0=1 only, which re-arms the cell pass bit -> M_CHK.
  - DONE: res_valid=1. Results hold stable until res_ready=1, then -> IDLE; busy and res_valid drop the same cycle.
- start while busy is ignored. Pulses are never asserted outside the states listed above.
- Counters saturate at all-ones and never wrap. MAX_STEPS must be < 2^CNT_W.
- Pulse outputs and nodes_reset are registered Moore outputs; no combinational path from the vector inputs.

Optional Feature:
GNR_TRANSIENT_EN
- Defined: full RELOAD/A/M phases as above; transient and attractor are the exact entry state.
- Undefined: L_CHK equal -> DONE directly with transient=0 and attractor=s0_vec at that point (a state on the cycle); the RELOAD/A/M states are absent.

Test Plan:
- Cell-array model with a fixed point at init (mu=0, lambda=1) -> found=1, period=1, transient=0, attractor=init.
- Sequence with mu=3, lambda=4 -> found=1, period=4, transient=3, attractor=state index 3. Without GNR_TRANSIENT_EN: transient=0.
- Pure cycle of length 64 with MAX_STEPS=16 -> found=0 after n=16, period=transient=0.
- Hold res_ready=0 for 20 cycles in DONE -> outputs stable, busy=1. Pulse start during this window -> ignored. res_ready=1 -> IDLE next cycle.
- Assert rst during L_STEP -> next cycle all outputs 0 and IDLE. A new start reruns and gives correct results.
- Monitor pulses: in M_STEP/M_PAD pairs, count start_s0 pulses = 2x start_s1 pulses. No pulse ever appears in any CHK cycle.
